// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: requester handshakes plus register-bank write port of the writeback arbiter.
interface writeback_arbiter_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  alu_valid;
   logic [ADDR_WIDTH-1:0] alu_address;
   logic [DATA_WIDTH-1:0] alu_value;
   logic                  alu_ready;
   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_value;
   logic                  mem_ready;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] write_value;
   logic                  clearing;
   modport master (
      output alu_valid, alu_address, alu_value, mem_valid, mem_address, mem_value,
      input  alu_ready, mem_ready, write_enable, write_address, write_value, clearing
   );
   modport slave (
      input  alu_valid, alu_address, alu_value, mem_valid, mem_address, mem_value,
      output alu_ready, mem_ready, write_enable, write_address, write_value, clearing
   );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-bank write port between ALU and load writebacks,
// zeroing registers 1..NUM_REGS-1 after reset.
module writeback_arbiter #(
   parameter int NUM_REGS       = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input logic              clk,
   input logic              reset,
   writeback_arbiter_if.slave wb
);
   typedef enum logic {CLEAR, ARB} state_e;
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_REGS - 1);
   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clear_ptr_q;
   logic                  last_mem_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wval_q;
   logic                  clearing_q;
   logic                  grant_mem;
   logic                  grant_alu;
   logic [ADDR_WIDTH-1:0] sel_addr_d;
   logic [DATA_WIDTH-1:0] sel_val_d;
   // last_mem_q=0 favours mem when both requesters contend
   always_comb begin
      grant_mem  = state_q == ARB && !reset && wb.mem_valid &&
                   (FIXED_PRIORITY || !wb.alu_valid || !last_mem_q);
      grant_alu  = state_q == ARB && !reset && wb.alu_valid && !grant_mem;
      sel_addr_d = grant_mem ? wb.mem_address : wb.alu_address;
      sel_val_d  = grant_mem ? wb.mem_value : wb.alu_value;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= CLEAR_ON_RESET ? CLEAR : ARB;
         clear_ptr_q <= ADDR_WIDTH'(1);
         last_mem_q  <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wval_q      <= '0;
         clearing_q  <= CLEAR_ON_RESET;
      end else if (state_q == CLEAR) begin
         we_q        <= 1'b1;
         waddr_q     <= clear_ptr_q;
         wval_q      <= '0;
         clear_ptr_q <= clear_ptr_q + 1'b1;
         if (clear_ptr_q == LAST) state_q <= ARB;
      end else begin
         // clearing stays high while the final clear write is on the bus
         clearing_q <= 1'b0;
         we_q       <= (grant_mem || grant_alu) && sel_addr_d != '0;
         waddr_q    <= sel_addr_d;
         wval_q     <= sel_val_d;
         if (grant_mem || grant_alu) last_mem_q <= grant_mem;
      end
   end
   assign wb.mem_ready     = grant_mem;
   assign wb.alu_ready     = grant_alu;
   assign wb.write_enable  = we_q;
   assign wb.write_address = waddr_q;
   assign wb.write_value   = wval_q;
   assign wb.clearing      = clearing_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed checks of clear sequence, arbitration and write latency.
module tb_writeback_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   passes = 0;
   writeback_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
   writeback_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) fp ();
   writeback_arbiter dut (.clk(clk), .reset(reset), .wb(bus.slave));
   writeback_arbiter #(.CLEAR_ON_RESET(1'b0), .FIXED_PRIORITY(1'b1)) dut_fp (.clk(clk), .reset(reset), .wb(fp.slave));
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_address = 5'd1; bus.alu_value = 32'h1;
      bus.mem_valid = 1'b1; bus.mem_address = 5'd2; bus.mem_value = 32'h2;
      fp.alu_valid = 1'b0; fp.alu_address = '0; fp.alu_value = '0;
      fp.mem_valid = 1'b0; fp.mem_address = '0; fp.mem_value = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.write_enable, bus.write_address, bus.write_value} !== 38'h0)
         $display("FAIL reset_write: got we=%b addr=%0d val=%h want 0/0/0", bus.write_enable, bus.write_address, bus.write_value);
      else passes++;
      checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b00)
         $display("FAIL reset_ready: got alu=%b mem=%b want 0/0", bus.alu_ready, bus.mem_ready);
      else passes++;
      checks++;
      if (bus.clearing !== 1'b1) $display("FAIL reset_clearing: got %b want 1", bus.clearing);
      else passes++;
      checks++;
      if (fp.clearing !== 1'b0) $display("FAIL reset_clearing_noclr: got %b want 0", fp.clearing);
      else passes++;
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
   endtask

   task automatic test_clear();
      reset = 1'b0;
      bus.alu_valid = 1'b1; bus.mem_valid = 1'b1;
      for (int i = 1; i <= 31; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({bus.write_enable, bus.write_address, bus.write_value} !== {1'b1, 5'(i), 32'h0})
            $display("FAIL clear_write: got we=%b addr=%0d val=%h want 1/%0d/0", bus.write_enable, bus.write_address, bus.write_value, i);
         else passes++;
         checks++;
         if (bus.clearing !== 1'b1) $display("FAIL clear_flag: step %0d got %b want 1", i, bus.clearing);
         else passes++;
         if (i == 31) begin bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; end
         #1;
         checks++;
         if ({bus.alu_ready, bus.mem_ready} !== 2'b00)
            $display("FAIL clear_ready: step %0d got alu=%b mem=%b want 0/0", i, bus.alu_ready, bus.mem_ready);
         else passes++;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.clearing, bus.write_enable} !== 2'b00)
         $display("FAIL clear_done: got clearing=%b we=%b want 0/0", bus.clearing, bus.write_enable);
      else passes++;
   endtask

   task automatic test_single_alu();
      bus.alu_valid = 1'b1; bus.alu_address = 5'd5; bus.alu_value = 32'hDEADBEEF;
      #1;
      checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b10)
         $display("FAIL alu_ready: got alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready);
      else passes++;
      @(posedge clk);
      #1;
      bus.alu_valid = 1'b0;
      checks++;
      if ({bus.write_enable, bus.write_address, bus.write_value} !== {1'b1, 5'd5, 32'hDEADBEEF})
         $display("FAIL alu_write: got we=%b addr=%0d val=%h want 1/5/deadbeef", bus.write_enable, bus.write_address, bus.write_value);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if (bus.write_enable !== 1'b0) $display("FAIL idle_we: got %b want 0", bus.write_enable);
      else passes++;
   endtask

   task automatic test_round_robin();
      bus.mem_valid = 1'b1; bus.mem_address = 5'd3; bus.mem_value = 32'hA0;
      bus.alu_valid = 1'b1; bus.alu_address = 5'd4; bus.alu_value = 32'hB0;
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++;
         if ({bus.alu_ready, bus.mem_ready} !== ((j % 2) ? 2'b10 : 2'b01))
            $display("FAIL rr_grant: cycle %0d got alu=%b mem=%b want %s", j, bus.alu_ready, bus.mem_ready, (j % 2) ? "alu" : "mem");
         else passes++;
         @(posedge clk);
         #1;
         checks++;
         if ({bus.write_enable, bus.write_address, bus.write_value} !== ((j % 2) ? {1'b1, 5'd4, 32'hB0} : {1'b1, 5'd3, 32'hA0}))
            $display("FAIL rr_write: cycle %0d got we=%b addr=%0d val=%h", j, bus.write_enable, bus.write_address, bus.write_value);
         else passes++;
      end
      bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
   endtask

   task automatic test_same_addr();
      bus.mem_valid = 1'b1; bus.mem_address = 5'd7; bus.mem_value = 32'h22;
      bus.alu_valid = 1'b1; bus.alu_address = 5'd7; bus.alu_value = 32'h11;
      #1;
      checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b01)
         $display("FAIL same_first: got alu=%b mem=%b want 0/1", bus.alu_ready, bus.mem_ready);
      else passes++;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      checks++;
      if ({bus.write_enable, bus.write_address, bus.write_value} !== {1'b1, 5'd7, 32'h22})
         $display("FAIL same_write1: got we=%b addr=%0d val=%h want 1/7/22", bus.write_enable, bus.write_address, bus.write_value);
      else passes++;
      #1;
      checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b10)
         $display("FAIL same_second: got alu=%b mem=%b want 1/0", bus.alu_ready, bus.mem_ready);
      else passes++;
      @(posedge clk);
      #1;
      bus.alu_valid = 1'b0;
      checks++;
      if ({bus.write_enable, bus.write_address, bus.write_value} !== {1'b1, 5'd7, 32'h11})
         $display("FAIL same_write2: got we=%b addr=%0d val=%h want 1/7/11", bus.write_enable, bus.write_address, bus.write_value);
      else passes++;
   endtask

   task automatic test_addr0();
      bus.mem_valid = 1'b1; bus.mem_address = 5'd0; bus.mem_value = 32'h1234;
      #1;
      checks++;
      if (bus.mem_ready !== 1'b1) $display("FAIL addr0_ready: got %b want 1", bus.mem_ready);
      else passes++;
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      checks++;
      if (bus.write_enable !== 1'b0) $display("FAIL addr0_we: got %b want 0", bus.write_enable);
      else passes++;
   endtask

   task automatic test_fixed_priority();
      fp.mem_valid = 1'b1; fp.mem_address = 5'd2; fp.mem_value = 32'hC0;
      fp.alu_valid = 1'b1; fp.alu_address = 5'd6; fp.alu_value = 32'hD0;
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++;
         if ({fp.alu_ready, fp.mem_ready} !== 2'b01)
            $display("FAIL fp_grant: cycle %0d got alu=%b mem=%b want 0/1", j, fp.alu_ready, fp.mem_ready);
         else passes++;
         @(posedge clk);
         #1;
         checks++;
         if ({fp.write_enable, fp.write_address, fp.write_value} !== {1'b1, 5'd2, 32'hC0})
            $display("FAIL fp_write: cycle %0d got we=%b addr=%0d val=%h want 1/2/c0", j, fp.write_enable, fp.write_address, fp.write_value);
         else passes++;
      end
      fp.mem_valid = 1'b0;
      #1;
      checks++;
      if (fp.alu_ready !== 1'b1) $display("FAIL fp_alu_ready: got %b want 1", fp.alu_ready);
      else passes++;
      @(posedge clk);
      #1;
      fp.alu_valid = 1'b0;
      checks++;
      if ({fp.write_enable, fp.write_address, fp.write_value} !== {1'b1, 5'd6, 32'hD0})
         $display("FAIL fp_alu_write: got we=%b addr=%0d val=%h want 1/6/d0", fp.write_enable, fp.write_address, fp.write_value);
      else passes++;
   endtask

   task automatic test_reset_mid_clear();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if ({bus.write_enable, bus.write_address} !== {1'b1, 5'd10})
         $display("FAIL mid_at10: got we=%b addr=%0d want 1/10", bus.write_enable, bus.write_address);
      else passes++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.write_enable, bus.clearing} !== 2'b01)
         $display("FAIL mid_reset: got we=%b clearing=%b want 0/1", bus.write_enable, bus.clearing);
      else passes++;
      test_clear();
   endtask

   initial begin
      test_reset();
      test_clear();
      test_single_alu();
      test_round_robin();
      test_same_addr();
      test_addr0();
      test_fixed_priority();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
